// File: rtl/stream_fifo.sv
// Parametrised single-clock stream FIFO with level reporting, almost flags, sticky errors and clear.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise reads are registered.
module stream_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned LW      = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic [LW-1:0]    level_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty, wr_acc, rd_acc;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  assign rd_acc = rd_en_i && !empty;
  assign wr_acc = wr_en_i && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (wr_en_i & ~wr_acc);
      unf_d = unf_q | (rd_en_i & empty);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

`ifdef FIFO_FWFT_EN
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign rd_valid_o = !empty;
`else
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    if (clr_i) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_acc;
      if (rd_acc) rd_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
`endif

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty_o = (level_q <= LW'(AE_LEVEL));
  assign level_o        = level_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo with a queue-based reference model and scoreboard.
// Covers fill/overflow, pointer wrap, simultaneous read/write at full and empty, clear and reset.
module tb_stream_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_i;
  logic       wr_en_i;
  logic [7:0] wr_data_i;
  logic       rd_en_i;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic       full_o, empty_o, almost_full_o, almost_empty_o;
  logic [3:0] level_o;
  logic       overflow_o, underflow_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  logic       m_ovf, m_unf, m_rdv;
  logic [7:0] m_rd;

  stream_fifo #(
    .WIDTH(8),
    .DEPTH(8),
    .AF_LEVEL(6),
    .AE_LEVEL(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr_i(clr_i),
    .wr_en_i(wr_en_i),
    .wr_data_i(wr_data_i),
    .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o),
    .full_o(full_o),
    .empty_o(empty_o),
    .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o),
    .level_o(level_o),
    .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    int n;
    n = mq.size();
    chk({tag, "/level"}, 32'(level_o), 32'(n));
    chk({tag, "/full"}, 32'(full_o), 32'(n == 8));
    chk({tag, "/empty"}, 32'(empty_o), 32'(n == 0));
    chk({tag, "/afull"}, 32'(almost_full_o), 32'(n >= 6));
    chk({tag, "/aempty"}, 32'(almost_empty_o), 32'(n <= 2));
    chk({tag, "/ovf"}, 32'(overflow_o), 32'(m_ovf));
    chk({tag, "/unf"}, 32'(underflow_o), 32'(m_unf));
`ifdef FIFO_FWFT_EN
    chk({tag, "/rdv"}, 32'(rd_valid_o), 32'(n != 0));
    if (n != 0) chk({tag, "/rdata"}, 32'(rd_data_o), 32'(mq[0]));
`else
    chk({tag, "/rdv"}, 32'(rd_valid_o), 32'(m_rdv));
    chk({tag, "/rdata"}, 32'(rd_data_o), 32'(m_rd));
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cycle(input string tag, input logic wr, input logic [7:0] d, input logic rd);
    logic racc, wacc;
    racc = rd && (mq.size() != 0);
    wacc = wr && (mq.size() < 8 || racc);
    wr_en_i   = wr;
    wr_data_i = d;
    rd_en_i   = rd;
    @(posedge clk);
    #1;
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    if (wr && !wacc) m_ovf = 1'b1;
    if (rd && mq.size() == 0) m_unf = 1'b1;
    m_rdv = racc;
    if (racc) m_rd = mq.pop_front();
    if (wacc) mq.push_back(d);
    chk_state(tag);
  endtask

  task automatic do_clear(input string tag);
    clr_i = 1'b1;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rdv = 1'b0;
    chk_state(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rdv = 1'b0;
    m_rd  = 8'h00;
  endtask

  initial begin
    rst       = 1'b0;
    clr_i     = 1'b0;
    wr_en_i   = 1'b0;
    wr_data_i = 8'h00;
    rd_en_i   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk_state("reset");

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) cycle($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0);
    cycle("ovf", 1'b1, 8'hFF, 1'b0);
    for (int i = 1; i <= 8; i++) cycle($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1);
    do_clear("clr0");

    // Pointer wrap
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 5; k++) cycle($sformatf("wrap_w%0d", r * 5 + k), 1'b1, 8'(8'h10 + r * 5 + k), 1'b0);
      for (int k = 0; k < 5; k++) cycle($sformatf("wrap_r%0d", r * 5 + k), 1'b0, 8'h00, 1'b1);
    end

    // Simultaneous read/write while full
    for (int i = 0; i < 8; i++) cycle($sformatf("fullA%0d", i), 1'b1, 8'(8'hA0 + i), 1'b0);
    cycle("full_rw", 1'b1, 8'hB0, 1'b1);
    for (int i = 0; i < 8; i++) cycle($sformatf("fulldrain%0d", i), 1'b0, 8'h00, 1'b1);

    // Simultaneous read/write while empty
    cycle("empty_rw", 1'b1, 8'h55, 1'b1);
    cycle("empty_rd55", 1'b0, 8'h00, 1'b1);

    // Mid-stream clear with level 4 and overflow set
    for (int i = 0; i < 8; i++) cycle($sformatf("pre_ovf%0d", i), 1'b1, 8'(8'hC0 + i), 1'b0);
    cycle("set_ovf", 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 4; i++) cycle($sformatf("to4_%0d", i), 1'b0, 8'h00, 1'b1);
    do_clear("clr_mid");

    // Reset pulse in the middle of a write
    cycle("pre_rst0", 1'b1, 8'h61, 1'b0);
    cycle("pre_rst1", 1'b1, 8'h62, 1'b0);
    wr_en_i   = 1'b1;
    wr_data_i = 8'h77;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b1;
    wr_en_i = 1'b0;
    model_reset();
    chk_state("rst_mid");
    cycle("post_rst_w", 1'b1, 8'h99, 1'b0);
    cycle("post_rst_r", 1'b0, 8'h00, 1'b1);

`ifdef FIFO_FWFT_EN
    // Fall-through: word visible next cycle without rd_en, popped by rd_en
    cycle("fwft_w", 1'b1, 8'h3C, 1'b0);
    chk("fwft_show_rdv", 32'(rd_valid_o), 32'd1);
    chk("fwft_show_data", 32'(rd_data_o), 32'h3C);
    cycle("fwft_pop", 1'b0, 8'h00, 1'b1);
    chk("fwft_pop_empty", 32'(empty_o), 32'd1);
    chk("fwft_pop_rdv", 32'(rd_valid_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO for buffering byte/word streams between the keystream generator and its consumers. It generalises the team's fixed 256×8 buffer with configurable width and depth, correct simultaneous read/write handling and exact level reporting. It adds programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous clear. It sits between producer and consumer in a single clock domain.

## Interface

- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, 2..1024.
- AF_LEVEL, DEPTH-2, almost_full asserted when level ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when level ≤ AE_LEVEL.
- Derived: AW = $clog2(DEPTH); level width LW = AW+1.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear: empties FIFO, clears error flags.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data holds a valid popped/head word.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AF_LEVEL.
- almost_empty  out  1  level ≤ AE_LEVEL.
- level  out  LW  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full and not accepted.
- underflow  out  1  sticky: read attempted while empty.

## Operation

- Storage: DEPTH×WIDTH array, not reset. wr_ptr/rd_ptr are AW bits wide and wrap modulo DEPTH. level is a separate LW-bit counter.
- Write accepted (wr_acc) when wr_en && (!full || rd_acc). Accepted write stores wr_data at wr_ptr and increments wr_ptr.
- Read accepted (rd_acc) when rd_en && !empty. Accepted read increments rd_ptr.
- Level update:
  - wr_acc only: +1.
  - rd_acc only: −1.
  - Both, or neither: unchanged.
- Full + wr_en + rd_en: both are accepted, the level stays DEPTH, and the read returns the oldest word, not wr_data.
- Empty + wr_en + rd_en: the write is accepted, the read is rejected, underflow is set, and level becomes 1.
- Error flags:
  - overflow sets on wr_en && !wr_acc.
  - underflow sets on rd_en && empty.
  - Both flags hold until clr or rst.
- clr has priority over wr_en/rd_en in the same cycle. It zeroes pointers, level, rd_valid, overflow and underflow. rd_data holds its value.
- Flags full/empty/almost_* are combinational decodes of level.
- Reset values: pointers 0, level 0, rd_data 0, rd_valid 0, overflow 0, underflow 0. Therefore empty=1, full=0, almost_empty=1, and almost_full=0 for AF_LEVEL>0.

## Timing

- Write-to-read latency: a word written at edge N is counted in level after edge N and is readable from cycle N+1.
- Standard mode: on rd_acc at edge N, rd_data is registered with mem[rd_ptr] and rd_valid=1 during cycle N+1. rd_valid drops the cycle after a non-accepted read. rd_data holds its last value when no read is accepted.
- Flags and level reflect state after each edge. There is no lookahead.
- rst deassertion mid-operation discards all contents. The first accepted write after reset lands at address 0.

## Configuration

- FIFO_FWFT_EN defined: first-word fall-through.
  - rd_data = mem[rd_ptr], combinational; rd_valid = !empty.
  - rd_en acts as acknowledge/pop of the displayed word, with the same rd_acc/underflow rules.
  - Read latency is 0: a word written at edge N is visible on rd_data in cycle N+1.
- Undefined: standard registered read, as in Timing.

## Test plan

- Parameters WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 for all scenarios.
- Reset, then write 0x01..0x08 on 8 consecutive cycles.
  - Expect level 1..8, almost_full from level 6, full=1 after the 8th write.
  - A 9th wr_en of 0xFF sets overflow with level staying 8.
  - Reading 8 words returns 0x01..0x08 in order.
- Pointer wrap: write 5 and read 5, repeated 4 times with data 0x10+i. All 20 words are returned in order, and level returns to 0 each round.
- Full simultaneous: with the FIFO full of 0xA0..0xA7, assert wr_en=1 (0xB0) and rd_en=1 together. Expect rd_data=0xA0, level stays 8, and 0xB0 is read last after draining.
- Empty simultaneous: with level 0, assert wr_en=1 (0x55) and rd_en=1 together. Expect underflow=1, level=1, and the next read returns 0x55.
- Mid-stream clear/reset: with level 4 and overflow set, pulse clr → level 0, empty=1, overflow=0. Repeat with rst low for 1 cycle mid-write → all outputs at reset values.
- FIFO_FWFT_EN build: write 0x3C at edge N. Expect rd_valid=1 and rd_data=0x3C in cycle N+1 with no rd_en. rd_en for one cycle → empty=1 and rd_valid=0.
